// File: rtl/toy_pack.sv
// Shared icache widths and the linefill write request bundle.
// Used by the data-RAM scheduler and its linefill FIFO.
package toy_pack;

  localparam int ICACHE_INDEX_WIDTH     = 8;
  localparam int ICACHE_WAY_WIDTH       = 1;
  localparam int ICACHE_DATA_WIDTH      = 512;
  localparam int ICACHE_REQ_TXNID_WIDTH = 8;
  localparam int MSHR_ENTRY_INDEX_WIDTH = 3;

  typedef struct packed {
    logic [ICACHE_INDEX_WIDTH-1:0]     index;
    logic [ICACHE_WAY_WIDTH-1:0]       way;
    logic [ICACHE_DATA_WIDTH-1:0]      data;
    logic [ICACHE_REQ_TXNID_WIDTH-1:0] txnid;
    logic [MSHR_ENTRY_INDEX_WIDTH-1:0] entry_idx;
  } lf_wr_req_t;

endpackage

// File: rtl/icache_lf_wr_fifo.sv
// Linefill write buffer: DEPTH entries, pointer + count, full/empty flags.
// Caller only pushes when not full and only pops when not empty.
module icache_lf_wr_fifo
  import toy_pack::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  lf_wr_req_t wr_req_i,
  input  logic       pop_i,
  output lf_wr_req_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  lf_wr_req_t    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] cnt_q;

  // Pointer and occupancy bookkeeping; reset drops buffered fills.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Entry storage, no reset needed: validity comes from the count.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wr_req_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/icache_dataram_sched.sv
// Single-port icache data SRAM scheduler: hit reads vs buffered linefills.
// Optional perf counters: define ICACHE_DRAM_SCHED_PERF_EN.
module icache_dataram_sched
  import toy_pack::*;
#(
  parameter int INDEX_WIDTH     = ICACHE_INDEX_WIDTH,
  parameter int WAY_WIDTH       = ICACHE_WAY_WIDTH,
  parameter int DATA_WIDTH      = ICACHE_DATA_WIDTH,
  parameter int TXNID_WIDTH     = ICACHE_REQ_TXNID_WIDTH,
  parameter int ENTRY_IDX_WIDTH = MSHR_ENTRY_INDEX_WIDTH,
  parameter int LF_FIFO_DEPTH   = 2,
  parameter int WR_STARVE_MAX   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rd_vld,
  output logic                           rd_rdy,
  input  logic [INDEX_WIDTH-1:0]         rd_index,
  input  logic [WAY_WIDTH-1:0]           rd_way,
  input  logic [TXNID_WIDTH-1:0]         rd_txnid,
  input  logic                           lf_vld,
  output logic                           lf_rdy,
  input  logic [INDEX_WIDTH-1:0]         lf_index,
  input  logic [WAY_WIDTH-1:0]           lf_way,
  input  logic [DATA_WIDTH-1:0]          lf_data,
  input  logic [TXNID_WIDTH-1:0]         lf_txnid,
  input  logic [ENTRY_IDX_WIDTH-1:0]     lf_entry_idx,
  output logic                           dram_en,
  output logic                           dram_wr_en,
  output logic [INDEX_WIDTH+WAY_WIDTH-1:0] dram_addr,
  output logic [DATA_WIDTH-1:0]          dram_wdata,
  input  logic [DATA_WIDTH-1:0]          dram_rdata,
  output logic                           lf_done,
  output logic [ENTRY_IDX_WIDTH-1:0]     lf_done_entry_idx,
  output logic                           up_vld,
  output logic [DATA_WIDTH-1:0]          up_data,
  output logic [TXNID_WIDTH-1:0]         up_txnid
`ifdef ICACHE_DRAM_SCHED_PERF_EN
  ,
  output logic [31:0]                    perf_rd_cnt,
  output logic [31:0]                    perf_wr_cnt,
  output logic [31:0]                    perf_force_cnt
`endif
);

  localparam int SW = $clog2(WR_STARVE_MAX + 1);

  lf_wr_req_t fifo_in;
  lf_wr_req_t fifo_head;
  logic       fifo_full;
  logic       fifo_empty;
  logic       fifo_push;
  logic       wr_force;
  logic       rd_gnt;
  logic       wr_gnt;

  logic [SW-1:0]          starve_q;
  logic                   rsp_vld_q;
  logic                   rsp_rd_q;
  logic [TXNID_WIDTH-1:0] rsp_txnid_q;
  logic [DATA_WIDTH-1:0]  rsp_data_q;

  assign fifo_in = '{
    index:     lf_index,
    way:       lf_way,
    data:      lf_data,
    txnid:     lf_txnid,
    entry_idx: lf_entry_idx
  };

  icache_lf_wr_fifo #(
    .DEPTH (LF_FIFO_DEPTH)
  ) u_lf_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (fifo_push),
    .wr_req_i (fifo_in),
    .pop_i    (wr_gnt),
    .head_o   (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
  );

  // Arbitration: a waiting fill wins when the buffer is full or reads starved it.
  always_comb begin
    wr_force = !fifo_empty &&
               (fifo_full || starve_q == SW'(WR_STARVE_MAX));
    rd_rdy   = !rst && !wr_force;
    lf_rdy   = !rst && !fifo_full;
    rd_gnt   = rd_vld && rd_rdy;
    wr_gnt   = !rst && !fifo_empty && (wr_force || !rd_vld);
    fifo_push = lf_vld && lf_rdy;

    dram_en           = 1'b0;
    dram_wr_en        = 1'b0;
    dram_addr         = '0;
    dram_wdata        = '0;
    lf_done           = 1'b0;
    lf_done_entry_idx = '0;
    if (rd_gnt) begin
      dram_en   = 1'b1;
      dram_addr = {rd_index, rd_way};
    end else if (wr_gnt) begin
      dram_en           = 1'b1;
      dram_wr_en        = 1'b1;
      dram_addr         = {fifo_head.index, fifo_head.way};
      dram_wdata        = fifo_head.data;
      lf_done           = 1'b1;
      lf_done_entry_idx = fifo_head.entry_idx;
    end
  end

  // Consecutive reads granted while a fill waits; saturates at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else if (wr_gnt || fifo_empty) begin
      starve_q <= '0;
    end else if (rd_gnt && starve_q != SW'(WR_STARVE_MAX)) begin
      starve_q <= starve_q + 1'b1;
    end
  end

  // Response stage: remember what was granted so data returns one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_vld_q   <= 1'b0;
      rsp_rd_q    <= 1'b0;
      rsp_txnid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      rsp_vld_q   <= rd_gnt || wr_gnt;
      rsp_rd_q    <= rd_gnt;
      rsp_txnid_q <= rd_gnt ? rd_txnid :
                     wr_gnt ? fifo_head.txnid : '0;
      rsp_data_q  <= wr_gnt ? fifo_head.data : '0;
    end
  end

  assign up_vld   = rsp_vld_q;
  assign up_txnid = rsp_txnid_q;
  assign up_data  = rsp_rd_q ? dram_rdata : rsp_data_q;

`ifdef ICACHE_DRAM_SCHED_PERF_EN
  logic [31:0] perf_rd_q;
  logic [31:0] perf_wr_q;
  logic [31:0] perf_force_q;

  // Grant counters, free-running and wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_rd_q    <= '0;
      perf_wr_q    <= '0;
      perf_force_q <= '0;
    end else begin
      if (rd_gnt) perf_rd_q <= perf_rd_q + 32'd1;
      if (wr_gnt) perf_wr_q <= perf_wr_q + 32'd1;
      if (wr_gnt && wr_force) perf_force_q <= perf_force_q + 32'd1;
    end
  end

  assign perf_rd_cnt    = perf_rd_q;
  assign perf_wr_cnt    = perf_wr_q;
  assign perf_force_cnt = perf_force_q;
`endif

endmodule

// File: tb/tb_icache_dataram_sched.sv
// Bench for icache_dataram_sched: SRAM model, shadow memory, response scoreboard.
// Build without ICACHE_DRAM_SCHED_PERF_EN.
module tb_icache_dataram_sched;
  import toy_pack::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         rd_vld;
  logic         rd_rdy;
  logic [7:0]   rd_index;
  logic [0:0]   rd_way;
  logic [7:0]   rd_txnid;
  logic         lf_vld;
  logic         lf_rdy;
  logic [7:0]   lf_index;
  logic [0:0]   lf_way;
  logic [511:0] lf_data;
  logic [7:0]   lf_txnid;
  logic [2:0]   lf_entry_idx;
  logic         dram_en;
  logic         dram_wr_en;
  logic [8:0]   dram_addr;
  logic [511:0] dram_wdata;
  logic [511:0] dram_rdata;
  logic         lf_done;
  logic [2:0]   lf_done_entry_idx;
  logic         up_vld;
  logic [511:0] up_data;
  logic [7:0]   up_txnid;

  always #5 clk = ~clk;

  icache_dataram_sched dut (
    .clk               (clk),
    .rst               (rst),
    .rd_vld            (rd_vld),
    .rd_rdy            (rd_rdy),
    .rd_index          (rd_index),
    .rd_way            (rd_way),
    .rd_txnid          (rd_txnid),
    .lf_vld            (lf_vld),
    .lf_rdy            (lf_rdy),
    .lf_index          (lf_index),
    .lf_way            (lf_way),
    .lf_data           (lf_data),
    .lf_txnid          (lf_txnid),
    .lf_entry_idx      (lf_entry_idx),
    .dram_en           (dram_en),
    .dram_wr_en        (dram_wr_en),
    .dram_addr         (dram_addr),
    .dram_wdata        (dram_wdata),
    .dram_rdata        (dram_rdata),
    .lf_done           (lf_done),
    .lf_done_entry_idx (lf_done_entry_idx),
    .up_vld            (up_vld),
    .up_data           (up_data),
    .up_txnid          (up_txnid)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  task automatic chk(string tag, logic [511:0] got, logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] init_pat(logic [8:0] a);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(a);
    return {16{w}};
  endfunction

  // SRAM model: one-cycle read latency, writes land at the edge.
  logic [511:0] sram [512];
  bit           sram_wr [512];
  always @(posedge clk) begin
    if (dram_en) begin
      if (dram_wr_en) begin
        sram[dram_addr]    <= dram_wdata;
        sram_wr[dram_addr] <= 1'b1;
      end else begin
        dram_rdata <= sram_wr[dram_addr] ? sram[dram_addr]
                                         : init_pat(dram_addr);
      end
    end
  end

  // Shadow of what the array should hold, updated by bench expectations.
  logic [511:0] ref_mem [512];
  bit           ref_wr [512];
  function automatic logic [511:0] ref_rd(logic [8:0] a);
    return ref_wr[a] ? ref_mem[a] : init_pat(a);
  endfunction

  typedef struct {
    logic [511:0] data;
    logic [7:0]   txnid;
    int           due;
  } rsp_t;
  rsp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic exp_rsp(logic [511:0] d, logic [7:0] t);
    sb.push_back('{d, t, cyc + 1});
  endtask

  // Scoreboard: each granted access must come back exactly one cycle later.
  always @(negedge clk) begin : mon
    rsp_t e;
    if (!rst) begin
      if (up_vld) begin
        if (sb.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("rsp_cycle", cyc, e.due);
          chk("rsp_data", up_data, e.data);
          chk("rsp_txnid", up_txnid, e.txnid);
        end
      end else if (sb.size() != 0 && sb[0].due <= cyc) begin
        chk("rsp_missing", 0, 1);
        void'(sb.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(bit v, logic [7:0] idx, bit way, logic [7:0] t);
    rd_vld   = v;
    rd_index = idx;
    rd_way   = way;
    rd_txnid = t;
  endtask

  task automatic set_lf(bit v, lf_wr_req_t r);
    lf_vld       = v;
    lf_index     = r.index;
    lf_way       = r.way;
    lf_data      = r.data;
    lf_txnid     = r.txnid;
    lf_entry_idx = r.entry_idx;
  endtask

  function automatic lf_wr_req_t mk_lf(logic [7:0] idx, bit way,
                                       logic [2:0] e, logic [7:0] t,
                                       logic [31:0] seed);
    lf_wr_req_t r;
    r.index     = idx;
    r.way       = way;
    r.data      = {16{seed}};
    r.txnid     = t;
    r.entry_idx = e;
    return r;
  endfunction

  task automatic exp_read(logic [7:0] idx, bit way, logic [7:0] t);
    logic [8:0] a;
    a = {idx, way};
    chk("rd_rdy", rd_rdy, 1);
    chk("rd_en", dram_en, 1);
    chk("rd_wr_en", dram_wr_en, 0);
    chk("rd_addr", dram_addr, a);
    chk("rd_lf_done", lf_done, 0);
    exp_rsp(ref_rd(a), t);
  endtask

  task automatic exp_write(lf_wr_req_t r);
    logic [8:0] a;
    a = {r.index, r.way};
    chk("wr_en", dram_en, 1);
    chk("wr_wr_en", dram_wr_en, 1);
    chk("wr_addr", dram_addr, a);
    chk("wr_wdata", dram_wdata, r.data);
    chk("wr_lf_done", lf_done, 1);
    chk("wr_entry", lf_done_entry_idx, r.entry_idx);
    exp_rsp(r.data, r.txnid);
    ref_mem[a] = r.data;
    ref_wr[a]  = 1'b1;
  endtask

  // Stream reads until the pending fill is forced in; count the reads granted.
  task automatic rd_until_write(int exp_n, lf_wr_req_t w);
    int  n;
    bit  done;
    n    = 0;
    done = 0;
    for (int k = 0; k < 10 && !done; k++) begin
      set_rd(1, 8'h50 + 8'(k), 0, 8'h20 + 8'(k));
      #1;
      if (rd_rdy) begin
        exp_read(8'h50 + 8'(k), 0, 8'h20 + 8'(k));
        n++;
        tick();
      end else begin
        done = 1;
      end
    end
    chk("starve_reads", n, exp_n);
    chk("force_rd_rdy", rd_rdy, 0);
    exp_write(w);
    tick();
  endtask

  lf_wr_req_t zero_lf;
  lf_wr_req_t fa, fb, fc, fx;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    zero_lf = mk_lf(0, 0, 0, 0, 0);
    rst = 1'b1;
    set_rd(1, 8'h12, 1, 8'h05);
    set_lf(1, mk_lf(8'h01, 0, 1, 8'h01, 32'h11111111));

    // Reset with both requesters active.
    repeat (3) begin
      tick();
      chk("rst_lf_rdy", lf_rdy, 0);
      chk("rst_rd_rdy", rd_rdy, 0);
      chk("rst_dram_en", dram_en, 0);
      chk("rst_dram_addr", dram_addr, 0);
      chk("rst_lf_done", lf_done, 0);
      chk("rst_up_vld", up_vld, 0);
      chk("rst_up_data", up_data, 0);
      chk("rst_up_txnid", up_txnid, 0);
    end
    rst = 1'b0;
    set_rd(0, 0, 0, 0);
    set_lf(0, zero_lf);
    #1;
    chk("post_rst_lf_rdy", lf_rdy, 1);
    chk("post_rst_rd_rdy", rd_rdy, 1);
    chk("post_rst_dram_en", dram_en, 0);
    tick();

    // Lone read.
    set_rd(1, 8'h12, 1, 8'h05);
    #1;
    chk("lone_rd_addr", dram_addr, 9'h025);
    exp_read(8'h12, 1, 8'h05);
    tick();
    set_rd(0, 0, 0, 0);
    #1;
    chk("lone_rd_up_vld", up_vld, 1);
    chk("lone_rd_up_txnid", up_txnid, 8'h05);
    tick();

    // Lone fill.
    fa = mk_lf(8'h12, 1, 3, 8'h09, 32'hDEAD0001);
    set_lf(1, fa);
    #1;
    chk("lone_lf_rdy", lf_rdy, 1);
    chk("lone_lf_idle", dram_en, 0);
    tick();
    set_lf(0, zero_lf);
    #1;
    exp_write(fa);
    tick();
    chk("lone_lf_up_vld", up_vld, 1);
    chk("lone_lf_up_data", up_data, fa.data);
    chk("lone_lf_up_txnid", up_txnid, 8'h09);
    tick();

    // Continuous reads with one fill, twice: starvation limit then clear.
    for (int r = 0; r < 2; r++) begin
      fb = mk_lf(8'h33 + 8'(r), 0, 3'(r), 8'h70 + 8'(r),
                 32'hF1110000 + 32'(r));
      set_rd(1, 8'h60, 1, 8'h11);
      set_lf(1, fb);
      #1;
      chk("st_lf_rdy", lf_rdy, 1);
      exp_read(8'h60, 1, 8'h11);
      tick();
      set_lf(0, zero_lf);
      rd_until_write(4, fb);
    end

    // Three back-to-back fills under continuous reads.
    fa = mk_lf(8'h70, 0, 4, 8'h81, 32'hAAAA0001);
    fb = mk_lf(8'h71, 1, 5, 8'h82, 32'hBBBB0002);
    fc = mk_lf(8'h72, 0, 6, 8'h83, 32'hCCCC0003);
    set_rd(1, 8'h61, 0, 8'h31);
    set_lf(1, fa);
    #1;
    chk("b2b_a_rdy", lf_rdy, 1);
    exp_read(8'h61, 0, 8'h31);
    tick();
    set_rd(1, 8'h62, 0, 8'h32);
    set_lf(1, fb);
    #1;
    chk("b2b_b_rdy", lf_rdy, 1);
    exp_read(8'h62, 0, 8'h32);
    tick();
    set_rd(1, 8'h63, 0, 8'h33);
    set_lf(1, fc);
    #1;
    chk("full_lf_rdy", lf_rdy, 0);
    chk("full_rd_rdy", rd_rdy, 0);
    exp_write(fa);
    tick();
    set_rd(1, 8'h64, 0, 8'h34);
    #1;
    chk("b2b_c_rdy", lf_rdy, 1);
    exp_read(8'h64, 0, 8'h34);
    tick();
    set_lf(0, zero_lf);
    #1;
    chk("full2_rd_rdy", rd_rdy, 0);
    exp_write(fb);
    tick();
    rd_until_write(4, fc);

    // Fill then read of the same line in the following cycle.
    set_rd(0, 0, 0, 0);
    fx = mk_lf(8'h40, 0, 2, 8'h44, 32'h5A5A0040);
    set_lf(1, fx);
    #1;
    chk("raw_idle", dram_en, 0);
    tick();
    set_lf(0, zero_lf);
    #1;
    exp_write(fx);
    tick();
    set_rd(1, 8'h40, 0, 8'h45);
    #1;
    exp_read(8'h40, 0, 8'h45);
    chk("raw_up_vld0", up_vld, 1);
    tick();
    set_rd(0, 0, 0, 0);
    #1;
    chk("raw_up_vld1", up_vld, 1);
    chk("raw_up_data", up_data, fx.data);
    chk("raw_up_txnid", up_txnid, 8'h45);
    tick();
    chk("idle_up_vld", up_vld, 0);
    chk("idle_up_data", up_data, 0);
    chk("idle_up_txnid", up_txnid, 0);

    repeat (2) tick();
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
